// File: rtl/gray_wptr_gen_if.sv
// Write-side pointer interface: write request, foreign read pointer in,
// accept / write address / Gray write pointer / full flags out.
// Optional almost_full signal present when GRAY_WPTR_ALMOST_FULL_EN is defined.
interface gray_wptr_gen_if #(
   parameter int unsigned ADDR_WIDTH = 4
);
   localparam int unsigned PW = ADDR_WIDTH + 1;

   logic                  inc;
   logic [PW-1:0]         rd_gray;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [PW-1:0]         wr_gray;
   logic                  full;
`ifdef GRAY_WPTR_ALMOST_FULL_EN
   logic                  almost_full;

   modport master (output inc, rd_gray,
                   input  accept, wr_addr, wr_gray, full, almost_full);
   modport slave  (input  inc, rd_gray,
                   output accept, wr_addr, wr_gray, full, almost_full);
`else
   modport master (output inc, rd_gray,
                   input  accept, wr_addr, wr_gray, full);
   modport slave  (input  inc, rd_gray,
                   output accept, wr_addr, wr_gray, full);
`endif
endinterface

// File: rtl/gray_wptr_gen.sv
// Async-FIFO write pointer generator: binary/Gray write pointer, remote read
// pointer synchronizer and registered full flag.
// Optional feature macro: GRAY_WPTR_ALMOST_FULL_EN (adds registered almost_full).
module gray_wptr_gen #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AF_LEVEL    = 2
) (
   input logic                clk,
   input logic                rst_n,
   gray_wptr_gen_if.slave     bus
);
   localparam int unsigned PW = ADDR_WIDTH + 1;

   // Elaboration-time parameter legality
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || AF_LEVEL > (2 ** ADDR_WIDTH)) begin : g_bad_param
      $error("gray_wptr_gen: illegal SYNC_STAGES or AF_LEVEL");
   end

   logic [PW-1:0]         sync_q [SYNC_STAGES];
   logic [PW-1:0]         rd_sync;
   logic [PW-1:0]         wbin_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [PW-1:0]         wr_gray_q;
   logic                  full_q;

   logic                  accept_c;
   logic [PW-1:0]         wbin_next_c;
   logic [PW-1:0]         gray_next_c;
   logic [PW-1:0]         full_tgt_c;

   assign rd_sync = sync_q[SYNC_STAGES-1];

   // Remote read pointer synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus.rd_gray;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Write acceptance and next pointer values
   always_comb begin
      accept_c    = bus.inc & ~full_q;
      wbin_next_c = wbin_q + PW'(accept_c);
      gray_next_c = wbin_next_c ^ (wbin_next_c >> 1);
   end

   // Full when the next write pointer laps the read pointer: top two Gray bits inverted
   if (ADDR_WIDTH == 1) begin : g_tgt_aw1
      assign full_tgt_c = ~rd_sync;
   end else begin : g_tgt_awn
      assign full_tgt_c = {~rd_sync[PW-1 -: 2], rd_sync[PW-3:0]};
   end

   // Pointer and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q    <= '0;
         wr_addr_q <= '0;
         wr_gray_q <= '0;
         full_q    <= 1'b0;
      end else begin
         wbin_q    <= wbin_next_c;
         wr_addr_q <= wbin_next_c[ADDR_WIDTH-1:0];
         wr_gray_q <= gray_next_c;
         full_q    <= (gray_next_c == full_tgt_c);
      end
   end

   assign bus.accept  = accept_c;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_gray = wr_gray_q;
   assign bus.full    = full_q;

`ifdef GRAY_WPTR_ALMOST_FULL_EN
   localparam int unsigned AF_THRESH = (2 ** ADDR_WIDTH) - AF_LEVEL;

   logic [PW-1:0] rd_bin_c;
   logic [PW-1:0] fill_c;
   logic          almost_full_q;

   // Gray-to-binary decode of the synchronized read pointer and fill level
   always_comb begin
      rd_bin_c = '0;
      for (int i = 0; i < int'(PW); i++) rd_bin_c[i] = ^(rd_sync >> i);
      fill_c = wbin_next_c - rd_bin_c;
   end

   // Almost-full flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) almost_full_q <= 1'b0;
      else        almost_full_q <= (fill_c >= PW'(AF_THRESH));
   end

   assign bus.almost_full = almost_full_q;
`endif
endmodule
